// File: rtl/prio_readout_sched_pkg.sv
// Shared types and helpers for the priority-readout scheduler and its slices.
package prio_readout_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_SETUP = 3'd2,
    ST_RUN   = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  localparam int BW_DEF    = 2;
  localparam int AW_DEF    = 6;
  localparam int MAX_NBANK = 8;
  localparam int MAX_AW    = 16;
  localparam int MAX_VEC_W = MAX_NBANK * MAX_AW;

  // Extract the aw-bit field of slice idx from a packed per-slice vector.
  function automatic logic [MAX_AW-1:0] slice_field(
    input logic [MAX_VEC_W-1:0] vec,
    input int unsigned          idx,
    input int unsigned          aw
  );
    logic [MAX_VEC_W-1:0] sh;
    logic [MAX_AW-1:0]    mask;
    sh   = vec >> (idx * aw);
    mask = MAX_AW'((33'd1 << aw) - 33'd1);
    return sh[MAX_AW-1:0] & mask;
  endfunction

endpackage

// File: rtl/prio_readout_sched_pick.sv
// Combinational lowest-set-bit encoder, shared with other arbiters.
module prio_pick_lowest #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          any_valid
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx       = '0;
    any_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx       = IW'(i);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_readout_sched.sv
// Per-crossing scheduler: broadcasts init/setup, grants the shared read port
// lowest-index first, tags returning data and enforces the cycle budget.
module prio_readout_sched
  import prio_readout_sched_pkg::*;
#(
  parameter int NBANK     = 4,
  parameter int BW        = BW_DEF,
  parameter int AW        = AW_DEF,
  parameter int SETUP_CYC = 2,
  parameter int BX_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NBANK-1:0]    has_dat,
  input  logic [NBANK*AW-1:0] slice_addr,
  input  logic [NBANK-1:0]    slice_valid,
  output logic                init,
  output logic                setup,
  output logic [NBANK-1:0]    sel,
  output logic [BW+AW-1:0]    rd_addr,
  output logic                dat_valid,
  output logic [BW-1:0]       dat_bank,
  output logic                busy,
  output logic                done,
  output logic                truncated,
  output state_e              dbg_state
);

  localparam int CW = $clog2(BX_CYCLES);
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
  // Expiry is decided one cycle early so the FIN cycle is the last of the
  // BX_CYCLES cycles counted from INIT.
  localparam logic [CW-1:0] EXPIRE_AT  = CW'(BX_CYCLES - 2);
  localparam logic [CW-1:0] CNT_MAX    = CW'(BX_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [BW-1:0]     grant_q, grant_d;
  logic              grant_vld_q, grant_vld_d;
  logic              trunc_q, trunc_set;
  logic [BW-1:0]     dat_bank_q;
  logic [BW+AW-1:0]  rd_hold_q;
  logic [BW-1:0]     pick_idx;
  logic              pick_any;
  logic              budget_hit;

  prio_pick_lowest #(.N(NBANK), .IW(BW)) u_pick (
    .req       (has_dat),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  assign budget_hit = (cnt_q == EXPIRE_AT);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_vld_d = grant_vld_q;
    trunc_set   = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_INIT;
      ST_INIT:  state_d = ST_SETUP;
      ST_SETUP: begin
        if (budget_hit) begin
          state_d   = ST_FIN;
          trunc_set = |has_dat;
        end else if (cnt_q >= SETUP_LAST) begin
          if (pick_any) grant_d = pick_idx;
          grant_vld_d = pick_any;
          state_d     = pick_any ? ST_RUN : ST_FIN;
        end
      end
      ST_RUN: begin
        if (budget_hit) begin
          state_d     = ST_FIN;
          grant_vld_d = 1'b0;
          trunc_set   = |has_dat;
        end else if (!(grant_vld_q && has_dat[grant_q])) begin
          if (pick_any) grant_d = pick_idx;
          grant_vld_d = pick_any;
          if (!pick_any) state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d     = ST_IDLE;
        grant_vld_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      grant_q     <= '0;
      grant_vld_q <= 1'b0;
      trunc_q     <= 1'b0;
      dat_bank_q  <= '0;
      rd_hold_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_vld_q <= grant_vld_d;
      dat_bank_q  <= grant_q;
      rd_hold_q   <= rd_addr;
      if (state_q == ST_IDLE && start) begin
        cnt_q   <= '0;
        trunc_q <= 1'b0;
      end else if (state_q != ST_IDLE && cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (trunc_set) trunc_q <= 1'b1;
    end
  end

  // sel is a pure grant with no back-pressure: a slice reads (and raises
  // slice_valid one cycle later) whenever it is selected and its count is
  // nonzero; a selected slice with nothing left simply idles.
  always_comb begin
    sel = '0;
    if (state_q == ST_RUN && grant_vld_q) sel = NBANK'(1) << grant_q;
  end

  always_comb begin
    rd_addr = rd_hold_q;
    if (|sel)
      rd_addr = {grant_q,
                 AW'(slice_field(MAX_VEC_W'(slice_addr), 32'(grant_q), AW))};
  end

  assign init      = (state_q == ST_INIT);
  assign setup     = (state_q == ST_INIT) || (state_q == ST_SETUP);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_FIN);
  assign truncated = trunc_q;
  assign dat_valid = |slice_valid;
  assign dat_bank  = dat_bank_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_prio_readout_sched.sv
// Directed bench for prio_readout_sched with a behavioural model of the slices.
module tb_prio_readout_sched;
  import prio_readout_sched_pkg::*;

  localparam int NBANK = 4;
  localparam int BW = 2;
  localparam int AW = 6;
  localparam int RW = BW + AW;
  localparam int NVEC = 6;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [NBANK-1:0]    has_dat;
  logic [NBANK*AW-1:0] slice_addr;
  logic [NBANK-1:0]    slice_valid;
  logic                init, setup, dat_valid, busy, done, truncated;
  logic [NBANK-1:0]    sel;
  logic [RW-1:0]       rd_addr;
  logic [BW-1:0]       dat_bank;
  state_e              dbg_state;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int   cnt [NBANK];
    int   exp_reads;
    int   exp_done_k;
    logic exp_trunc;
    bit   poke;
  } vec_t;

  vec_t vecs [NVEC];
  logic [AW-1:0] load_cnt [NBANK];
  logic [AW-1:0] sl_cnt [NBANK];
  logic [AW-1:0] sl_ptr [NBANK];
  logic [RW-1:0] exp_q [$];
  logic [BW-1:0] exp_bank_q [$];

  prio_readout_sched #(
    .NBANK(NBANK), .BW(BW), .AW(AW), .SETUP_CYC(2), .BX_CYCLES(64)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .has_dat(has_dat),
    .slice_addr(slice_addr), .slice_valid(slice_valid),
    .init(init), .setup(setup), .sel(sel), .rd_addr(rd_addr),
    .dat_valid(dat_valid), .dat_bank(dat_bank), .busy(busy), .done(done),
    .truncated(truncated), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // slice model: counters load on init, has_dat tracks the post-read count
  always @(posedge clk) begin
    for (int i = 0; i < NBANK; i++) begin
      if (rst) begin
        sl_cnt[i] <= '0;
        sl_ptr[i] <= '0;
        has_dat[i] <= 1'b0;
        slice_valid[i] <= 1'b0;
      end else if (init) begin
        sl_cnt[i] <= load_cnt[i];
        sl_ptr[i] <= '0;
        has_dat[i] <= (load_cnt[i] != '0);
        slice_valid[i] <= 1'b0;
      end else begin
        slice_valid[i] <= sel[i] && (sl_cnt[i] != '0);
        if (sel[i] && sl_cnt[i] != '0) begin
          sl_cnt[i] <= sl_cnt[i] - 1'b1;
          sl_ptr[i] <= sl_ptr[i] + 1'b1;
          has_dat[i] <= (sl_cnt[i] != AW'(1));
        end
      end
    end
  end

  always_comb begin
    slice_addr = '0;
    for (int i = 0; i < NBANK; i++) slice_addr[i*AW +: AW] = sl_ptr[i];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int v, input int c0, input int c1, input int c2, input int c3,
                         input int reads, input int done_k, input logic trunc, input bit poke);
    vecs[v].cnt[0] = c0;
    vecs[v].cnt[1] = c1;
    vecs[v].cnt[2] = c2;
    vecs[v].cnt[3] = c3;
    vecs[v].exp_reads = reads;
    vecs[v].exp_done_k = done_k;
    vecs[v].exp_trunc = trunc;
    vecs[v].poke = poke;
  endtask

  // driver + monitor for one crossing; start goes high in the next cycle
  task automatic run_vec(input int v);
    int k, init_n, setup_n, reads, dvs, done_k, extra;
    bit seen_done;
    logic [RW-1:0] e;
    k = -1; init_n = 0; setup_n = 0; reads = 0; dvs = 0; done_k = -1; extra = 0;
    seen_done = 1'b0;
    exp_q.delete();
    exp_bank_q.delete();
    for (int i = 0; i < NBANK; i++) load_cnt[i] = AW'(vecs[v].cnt[i]);
    for (int b = 0; b < NBANK; b++)
      for (int a = 0; a < vecs[v].cnt[b]; a++)
        if (exp_q.size() < vecs[v].exp_reads) begin
          exp_q.push_back(RW'((b << AW) | a));
          exp_bank_q.push_back(BW'(b));
        end
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 0; cyc < 200 && !seen_done; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (k < 0 && init) k = 0;
      else if (k >= 0) k++;
      if (init) init_n++;
      if (setup) setup_n++;
      if (k == 0) check("trunc_clear_at_init", 32'(truncated), 32'd0);
      for (int i = 0; i < NBANK; i++)
        if (sel[i] && sl_cnt[i] != '0) begin
          reads++;
          if (exp_q.size() == 0) check("unexpected_read", 32'(rd_addr), 32'hFFFF_FFFF);
          else begin
            e = exp_q.pop_front();
            check("rd_addr", 32'(rd_addr), 32'(e));
          end
        end
      if (dat_valid) begin
        dvs++;
        if (exp_bank_q.size() == 0) check("unexpected_dat_valid", 32'(dat_bank), 32'hFFFF_FFFF);
        else check("dat_bank", 32'(dat_bank), 32'(exp_bank_q.pop_front()));
      end
      if (done) begin
        seen_done = 1'b1;
        done_k = k;
        check("truncated_at_done", 32'(truncated), 32'(vecs[v].exp_trunc));
        check("sel_off_in_fin", 32'(sel), 32'd0);
      end
      if (vecs[v].poke && k == 5) start = 1'b1;
    end
    check("done_seen", 32'(seen_done), 32'd1);
    check("init_cycles", 32'(init_n), 32'd1);
    check("setup_cycles", 32'(setup_n), 32'd2);
    check("done_offset", 32'(done_k), 32'(vecs[v].exp_done_k));
    check("read_count", 32'(reads), 32'(vecs[v].exp_reads));
    check("dat_valid_count", 32'(dvs), 32'(vecs[v].exp_reads));
    if (vecs[v].poke) begin
      repeat (4) begin
        @(negedge clk);
        if (init || done) extra++;
      end
      check("single_done", 32'(extra), 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_init"}, 32'(init), 32'd0);
    check({tag, "_setup"}, 32'(setup), 32'd0);
    check({tag, "_sel"}, 32'(sel), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_dat_valid"}, 32'(dat_valid), 32'd0);
    check({tag, "_truncated"}, 32'(truncated), 32'd0);
    check({tag, "_dat_bank"}, 32'(dat_bank), 32'd0);
    check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    for (int i = 0; i < NBANK; i++) load_cnt[i] = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // counts, reads, done offset from init, truncated, start-while-busy
    set_vec(0, 3, 0, 2, 0, 5, 9, 1'b0, 1'b0);
    set_vec(1, 0, 0, 0, 0, 0, 2, 1'b0, 1'b0);
    set_vec(2, 40, 40, 0, 0, 60, 63, 1'b1, 1'b0);
    set_vec(3, 0, 0, 0, 5, 5, 8, 1'b0, 1'b0);
    set_vec(4, 1, 1, 1, 1, 4, 10, 1'b0, 1'b1);
    set_vec(5, 60, 0, 0, 0, 60, 63, 1'b0, 1'b0);
    for (int v = 0; v < NVEC; v++) run_vec(v);

    // reset in the middle of RUN
    load_cnt[0] = AW'(10);
    load_cnt[1] = AW'(10);
    load_cnt[2] = '0;
    load_cnt[3] = '0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("mid_init", 32'(init), 32'd1);
    repeat (5) @(negedge clk);
    check("mid_run_sel", 32'(sel), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    rst = 1'b0;
    run_vec(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
